dcache_nway: RTL

//  Parametrised write-back, write-allocate L1 data cache: N-way set-associative, true-LRU, multi-word blocks.

---
 rtl/dcache_nway_pkg.sv | 33 +++
 rtl/dcache_nway_lru.sv | 61 ++++++
 rtl/dcache_nway.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dcache_nway_pkg.sv
// Shared types and address helpers for the N-way write-back L1 data cache.
// Latency: n/a (types, defaults and pure functions only).
// Backpressure: n/a.
package dcache_nway_pkg;

  // Default geometry: 8 sets, 2 ways, 2 words per block.
  localparam int DC_SETS  = 8;
  localparam int DC_WAYS  = 2;
  localparam int DC_WORDS = 2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WB     = 3'd1,
    LD     = 3'd2,
    FLUSH  = 3'd3,
    FLWB   = 3'd4,
    HALTED = 3'd5
  } dc_state_t;

  // Byte address layout: {tag, idx[iw], blkoff[bw], 2'b00}.
  function automatic logic [31:0] addr_tag(input logic [31:0] a, input int iw, input int bw);
    return a >> (2 + iw + bw);
  endfunction

  function automatic logic [31:0] addr_idx(input logic [31:0] a, input int iw, input int bw);
    return (a >> (2 + bw)) & ((32'd1 << iw) - 32'd1);
  endfunction

  function automatic logic [31:0] addr_off(input logic [31:0] a, input int bw);
    return (a >> 2) & ((32'd1 << bw) - 32'd1);
  endfunction

endpackage

// File: rtl/dcache_nway_lru.sv
// True-LRU age tracking: one age per way per set, age 0 = MRU, age WAYS-1 = LRU.
// Latency: touch takes effect on the next edge; victim output is combinational.
// Backpressure: none; a touch is accepted every cycle it is enabled.
module dcache_nway_lru #(
  parameter  int SETS = 8,
  parameter  int WAYS = 2,
  localparam int IW   = $clog2(SETS),
  localparam int WAW  = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic           CLK,
  input  logic           nRST,
  input  logic           touch_en,
  input  logic [IW-1:0]  touch_set,
  input  logic [WAW-1:0] touch_way,
  input  logic [IW-1:0]  query_set,
  output logic [WAW-1:0] victim_way
);

  logic [WAW-1:0] age_q [SETS][WAYS];
  logic [WAW-1:0] age_d [SETS][WAYS];
  logic [WAW-1:0] old_age;

  // Touched way becomes MRU; ways that were younger than it age by one.
  always_comb begin
    age_d   = age_q;
    old_age = age_q[touch_set][touch_way];
    if (touch_en) begin
      for (int w = 0; w < WAYS; w++) begin
        if (WAW'(w) == touch_way) begin
          age_d[touch_set][w] = '0;
        end else if (age_q[touch_set][w] < old_age) begin
          age_d[touch_set][w] = age_q[touch_set][w] + 1'b1;
        end
      end
    end
  end

  // The oldest way of the queried set is the replacement candidate.
  always_comb begin
    victim_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (age_q[query_set][w] == WAW'(WAYS - 1)) begin
        victim_way = WAW'(w);
      end
    end
  end

  // Age registers; reset gives each way an age equal to its index.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          age_q[s][w] <= WAW'(w);
        end
      end
    end else begin
      age_q <= age_d;
    end
  end

endmodule

// File: rtl/dcache_nway.sv
// Write-back, write-allocate N-way set-associative L1 data cache with snoop replies and halt flush.
// Latency: hits answer combinationally in IDLE; misses take WORDS bus beats (plus WORDS for a dirty victim).
// Backpressure: dwait stalls every bus beat; the datapath holds its request until dhit.
module dcache_nway
  import dcache_nway_pkg::*;
#(
  parameter  int SETS  = DC_SETS,
  parameter  int WAYS  = DC_WAYS,
  parameter  int WORDS = DC_WORDS,
  localparam int IW    = $clog2(SETS),
  localparam int BW    = $clog2(WORDS),
  localparam int TW    = 30 - IW - BW,
  localparam int WAW   = (WAYS > 1) ? $clog2(WAYS) : 1,
  localparam int LW    = IW + $clog2(WAYS)
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        halt,
  input  logic        dmemREN,
  input  logic        dmemWEN,
  input  logic [31:0] dmemaddr,
  input  logic [31:0] dmemstore,
  output logic        dhit,
  output logic [31:0] dmemload,
  output logic        flushed,
  output logic        dREN,
  output logic        dWEN,
  output logic [31:0] daddr,
  output logic [31:0] dstore,
  input  logic [31:0] dload,
  input  logic        dwait,
  input  logic        ccwait,
  input  logic        ccinv,
  input  logic [31:0] ccsnoopaddr,
  output logic        ccwrite,
  output logic        cctrans
);

  // Line storage.
  logic [31:0]     data_q  [SETS][WAYS][WORDS];
  logic [31:0]     data_d  [SETS][WAYS][WORDS];
  logic [TW-1:0]   tag_q   [SETS][WAYS];
  logic [TW-1:0]   tag_d   [SETS][WAYS];
  logic [WAYS-1:0] valid_q [SETS];
  logic [WAYS-1:0] valid_d [SETS];
  logic [WAYS-1:0] dirty_q [SETS];
  logic [WAYS-1:0] dirty_d [SETS];

  // Control state.
  dc_state_t      state_q, state_d;
  logic [BW-1:0]  wc_q, wc_d;
  logic [LW-1:0]  lc_q, lc_d;
  logic [WAW-1:0] vic_q, vic_d;
  logic [TW-1:0]  mtag_q, mtag_d;
  logic [IW-1:0]  midx_q, midx_d;

  // Address fields of the request and of the snoop.
  logic [TW-1:0]  r_tag, s_tag;
  logic [IW-1:0]  r_idx, s_idx;
  logic [BW-1:0]  r_off, s_off;

  logic           hit, snp_hit, inv_found, req;
  logic [WAW-1:0] hit_way, snp_way, inv_way, lru_victim, vic_sel;
  logic [IW-1:0]  fl_set;
  logic [WAW-1:0] fl_way;
  logic           last_word, lc_last;
  logic [31:0]    fsm_addr, fsm_data;
  logic           fill_we, fill_done, wb_done, flwb_done;
  logic           touch_en;
  logic [IW-1:0]  touch_set;
  logic [WAW-1:0] touch_way;

  assign r_tag = TW'(addr_tag(dmemaddr, IW, BW));
  assign r_idx = IW'(addr_idx(dmemaddr, IW, BW));
  assign r_off = BW'(addr_off(dmemaddr, BW));
  assign s_tag = TW'(addr_tag(ccsnoopaddr, IW, BW));
  assign s_idx = IW'(addr_idx(ccsnoopaddr, IW, BW));
  assign s_off = BW'(addr_off(ccsnoopaddr, BW));

  assign req       = dmemREN | dmemWEN;
  assign fl_set    = lc_q[IW-1:0];
  assign fl_way    = WAW'(lc_q >> IW);
  assign last_word = (wc_q == BW'(WORDS - 1));
  assign lc_last   = (lc_q == LW'(SETS * WAYS - 1));

  // Tag lookup for the request and the snoop, plus the lowest invalid way of the request set.
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    snp_hit   = 1'b0;
    snp_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[r_idx][w] && (tag_q[r_idx][w] == r_tag)) begin
        hit     = 1'b1;
        hit_way = WAW'(w);
      end
      if (valid_q[s_idx][w] && (tag_q[s_idx][w] == s_tag)) begin
        snp_hit = 1'b1;
        snp_way = WAW'(w);
      end
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[r_idx][w]) begin
        inv_found = 1'b1;
        inv_way   = WAW'(w);
      end
    end
  end

  assign vic_sel  = inv_found ? inv_way : lru_victim;
  assign dhit     = req & hit & ~ccwait & (state_q == IDLE);
  assign cctrans  = dhit & dmemWEN;
  assign dmemload = data_q[r_idx][hit_way][r_off];
  assign ccwrite  = ccwait & snp_hit & dirty_q[s_idx][snp_way];
  assign dstore   = (ccwait && snp_hit) ? data_q[s_idx][snp_way][s_off] : fsm_data;
  assign daddr    = cctrans ? dmemaddr : fsm_addr;
  assign flushed  = (state_q == HALTED);

  // Next-state, counters and bus requests of the miss / flush controller.
  always_comb begin
    state_d   = state_q;
    wc_d      = wc_q;
    lc_d      = lc_q;
    vic_d     = vic_q;
    mtag_d    = mtag_q;
    midx_d    = midx_q;
    dREN      = 1'b0;
    dWEN      = 1'b0;
    fsm_addr  = '0;
    fsm_data  = '0;
    fill_we   = 1'b0;
    fill_done = 1'b0;
    wb_done   = 1'b0;
    flwb_done = 1'b0;
    unique case (state_q)
      IDLE: begin
        wc_d = '0;
        if (halt) begin
          state_d = FLUSH;
          lc_d    = '0;
        end else if (req && !hit) begin
          vic_d   = vic_sel;
          mtag_d  = r_tag;
          midx_d  = r_idx;
          state_d = (valid_q[r_idx][vic_sel] && dirty_q[r_idx][vic_sel]) ? WB : LD;
        end
      end
      WB: begin
        dWEN     = 1'b1;
        fsm_addr = {tag_q[midx_q][vic_q], midx_q, wc_q, 2'b00};
        fsm_data = data_q[midx_q][vic_q][wc_q];
        if (!dwait) begin
          if (last_word) begin
            wb_done = 1'b1;
            wc_d    = '0;
            state_d = LD;
          end else begin
            wc_d = wc_q + 1'b1;
          end
        end
      end
      LD: begin
        dREN     = 1'b1;
        fsm_addr = {mtag_q, midx_q, wc_q, 2'b00};
        if (!dwait) begin
          fill_we = 1'b1;
          if (last_word) begin
            fill_done = 1'b1;
            wc_d      = '0;
            state_d   = IDLE;
          end else begin
            wc_d = wc_q + 1'b1;
          end
        end
      end
      FLUSH: begin
        if (valid_q[fl_set][fl_way] && dirty_q[fl_set][fl_way]) begin
          state_d = FLWB;
          wc_d    = '0;
        end else begin
          lc_d = lc_q + 1'b1;
          if (lc_last) state_d = HALTED;
        end
      end
      FLWB: begin
        dWEN     = 1'b1;
        fsm_addr = {tag_q[fl_set][fl_way], fl_set, wc_q, 2'b00};
        fsm_data = data_q[fl_set][fl_way][wc_q];
        if (!dwait) begin
          if (last_word) begin
            flwb_done = 1'b1;
            wc_d      = '0;
            lc_d      = lc_q + 1'b1;
            state_d   = lc_last ? HALTED : FLUSH;
          end else begin
            wc_d = wc_q + 1'b1;
          end
        end
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Array updates in priority order: write hit, then snoop, then fill/writeback bookkeeping.
  always_comb begin
    data_d  = data_q;
    tag_d   = tag_q;
    valid_d = valid_q;
    dirty_d = dirty_q;
    if (cctrans) begin
      data_d[r_idx][hit_way][r_off] = dmemstore;
      dirty_d[r_idx][hit_way]       = 1'b1;
    end
    if (ccwrite) dirty_d[s_idx][snp_way] = 1'b0;
    if (ccinv && snp_hit) valid_d[s_idx][snp_way] = 1'b0;
    if (fill_we) data_d[midx_q][vic_q][wc_q] = dload;
    if (fill_done) begin
      // A snoop invalidating the very line being filled leaves it invalid.
      tag_d[midx_q][vic_q]   = mtag_q;
      valid_d[midx_q][vic_q] = !(ccinv && (s_idx == midx_q) && (s_tag == mtag_q));
      dirty_d[midx_q][vic_q] = 1'b0;
    end
    if (wb_done) dirty_d[midx_q][vic_q] = 1'b0;
    if (flwb_done) dirty_d[fl_set][fl_way] = 1'b0;
  end

  // Hits and completed fills refresh the LRU order.
  always_comb begin
    touch_en  = dhit | fill_done;
    touch_set = fill_done ? midx_q : r_idx;
    touch_way = fill_done ? vic_q : hit_way;
  end

  dcache_nway_lru #(
    .SETS (SETS),
    .WAYS (WAYS)
  ) u_lru (
    .CLK        (CLK),
    .nRST       (nRST),
    .touch_en   (touch_en),
    .touch_set  (touch_set),
    .touch_way  (touch_way),
    .query_set  (r_idx),
    .victim_way (lru_victim)
  );

  // Control and line-status registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      wc_q    <= '0;
      lc_q    <= '0;
      vic_q   <= '0;
      mtag_q  <= '0;
      midx_q  <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) begin
          tag_q[s][w] <= '0;
        end
      end
    end else begin
      state_q <= state_d;
      wc_q    <= wc_d;
      lc_q    <= lc_d;
      vic_q   <= vic_d;
      mtag_q  <= mtag_d;
      midx_q  <= midx_d;
      valid_q <= valid_d;
      dirty_q <= dirty_d;
      tag_q   <= tag_d;
    end
  end

  // Data words carry no reset; they are only read behind a valid bit.
  always_ff @(posedge CLK) begin
    data_q <= data_d;
  end

endmodule
